call_frame_stack: RTL and testbench

//  Hardware call/return frame stack feeding the stack/TOS datapath. On CALL it saves the

---
 rtl/call_frame_stack.sv | 147 ++++++++++++++
 tb/tb_call_frame_stack.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/call_frame_stack.sv
// Call/return frame stack: saves {return PC, caller TOS} on CALL and restores them on RETURN.
// Optional high-water monitor on MAX_DEPTH_OUT is built when CFS_DEPTH_MON_EN is defined.
module call_frame_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CALL_REQ,
    input  logic                  RET_REQ,
    input  logic [ADDR_WIDTH-1:0] CALL_PC_IN,
    input  logic [ADDR_WIDTH-1:0] CALL_TOS_IN,
    input  logic [DATA_WIDTH-1:0] RET_VALUE_IN,
    input  logic                  CLR_ERR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] RET_PC_OUT,
    output logic [ADDR_WIDTH-1:0] STACK_TOS_RETURN,
    output logic [DATA_WIDTH-1:0] REG_DATA_RETURN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DEPTH_LOG2:0]   DEPTH_OUT,
    output logic                  OVF_ERR,
    output logic                  UNF_ERR,
    output logic [DEPTH_LOG2:0]   MAX_DEPTH_OUT
);

    localparam int FRAMES = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] SP_FULL = (DEPTH_LOG2+1)'(FRAMES);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] tos;
    } frame_t;

    typedef enum logic [2:0] {IDLE, CALL_WR, RET_RD, RET_LD, ERR} state_t;

    state_t                state;
    frame_t                mem [FRAMES];
    frame_t                rd_frame;
    logic [DEPTH_LOG2:0]   sp;
    logic [DEPTH_LOG2:0]   sp_inc;
    logic [DEPTH_LOG2:0]   sp_dec;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  full;
    logic                  empty;
    logic                  call_go;
    logic                  ret_go;

    assign full    = (sp == SP_FULL);
    assign empty   = (sp == '0);
    assign sp_inc  = sp + 1'b1;
    assign sp_dec  = sp - 1'b1;
    assign wr_addr = sp[DEPTH_LOG2-1:0];
    assign rd_addr = sp_dec[DEPTH_LOG2-1:0];

    // CALL wins when both requests are up, so RET only proceeds with CALL_REQ low.
    assign call_go = (state == IDLE) && CALL_REQ && !full;
    assign ret_go  = (state == IDLE) && !CALL_REQ && RET_REQ && !empty;

    assign FULL      = full;
    assign EMPTY     = empty;
    assign DEPTH_OUT = sp;

    // Frame RAM: not reset, one-cycle synchronous read.
    always_ff @(posedge clk) begin
        if (call_go)
            mem[wr_addr] <= '{pc: CALL_PC_IN, tos: CALL_TOS_IN};
        if (ret_go)
            rd_frame <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            sp               <= '0;
            BUSY             <= 1'b0;
            DONE             <= 1'b0;
            RET_PC_OUT       <= '0;
            STACK_TOS_RETURN <= '0;
            REG_DATA_RETURN  <= '0;
            OVF_ERR          <= 1'b0;
            UNF_ERR          <= 1'b0;
        end else begin
            DONE <= 1'b0;
            BUSY <= 1'b0;
            // Clear first so a same-cycle error set below takes precedence.
            if (CLR_ERR) begin
                OVF_ERR <= 1'b0;
                UNF_ERR <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (CALL_REQ) begin
                        BUSY <= 1'b1;
                        DONE <= 1'b1;
                        if (!full) begin
                            sp    <= sp_inc;
                            state <= CALL_WR;
                        end else begin
                            OVF_ERR <= 1'b1;
                            state   <= ERR;
                        end
                    end else if (RET_REQ) begin
                        BUSY <= 1'b1;
                        if (!empty) begin
                            sp              <= sp_dec;
                            REG_DATA_RETURN <= RET_VALUE_IN;
                            state           <= RET_RD;
                        end else begin
                            UNF_ERR <= 1'b1;
                            DONE    <= 1'b1;
                            state   <= ERR;
                        end
                    end
                end
                RET_RD: begin
                    RET_PC_OUT       <= rd_frame.pc;
                    STACK_TOS_RETURN <= rd_frame.tos;
                    BUSY             <= 1'b1;
                    DONE             <= 1'b1;
                    state            <= RET_LD;
                end
                CALL_WR, RET_LD, ERR: state <= IDLE;
                default:              state <= IDLE;
            endcase
        end
    end

`ifdef CFS_DEPTH_MON_EN
    logic [DEPTH_LOG2:0] max_depth;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            max_depth <= '0;
        else if (call_go && (sp_inc > max_depth))
            max_depth <= sp_inc;
    end

    assign MAX_DEPTH_OUT = max_depth;
`else
    assign MAX_DEPTH_OUT = '0;
`endif

endmodule

// File: tb/tb_call_frame_stack.sv
// Directed self-checking bench for call_frame_stack.
module tb_call_frame_stack;
    logic        clk = 1'b0;
    logic        reset;
    logic        CALL_REQ, RET_REQ, CLR_ERR;
    logic [11:0] CALL_PC_IN, CALL_TOS_IN;
    logic [7:0]  RET_VALUE_IN;
    logic        BUSY, DONE, FULL, EMPTY, OVF_ERR, UNF_ERR;
    logic [11:0] RET_PC_OUT, STACK_TOS_RETURN;
    logic [7:0]  REG_DATA_RETURN;
    logic [4:0]  DEPTH_OUT, MAX_DEPTH_OUT;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    call_frame_stack #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .CALL_REQ(CALL_REQ), .RET_REQ(RET_REQ),
        .CALL_PC_IN(CALL_PC_IN), .CALL_TOS_IN(CALL_TOS_IN), .RET_VALUE_IN(RET_VALUE_IN),
        .CLR_ERR(CLR_ERR), .BUSY(BUSY), .DONE(DONE), .RET_PC_OUT(RET_PC_OUT),
        .STACK_TOS_RETURN(STACK_TOS_RETURN), .REG_DATA_RETURN(REG_DATA_RETURN),
        .FULL(FULL), .EMPTY(EMPTY), .DEPTH_OUT(DEPTH_OUT), .OVF_ERR(OVF_ERR),
        .UNF_ERR(UNF_ERR), .MAX_DEPTH_OUT(MAX_DEPTH_OUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise the requests, wait (bounded) for DONE, drop them in the DONE cycle.
    task automatic op(input logic c, input logic r, output int l);
        @(negedge clk);
        CALL_REQ = c;
        RET_REQ  = r;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!DONE && l < 8);
        CALL_REQ = 1'b0;
        RET_REQ  = 1'b0;
        if (!DONE) chk("done_timeout", 32'(DONE), 32'd1);
    endtask

    task automatic do_call(input logic [11:0] pc, input logic [11:0] tos, output int l);
        CALL_PC_IN  = pc;
        CALL_TOS_IN = tos;
        op(1'b1, 1'b0, l);
    endtask

    // Returns one cycle after DONE, when restored outputs are guaranteed.
    task automatic do_ret(input logic [7:0] val, output int l);
        RET_VALUE_IN = val;
        op(1'b0, 1'b1, l);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        CALL_REQ = 0; RET_REQ = 0; CLR_ERR = 0;
        CALL_PC_IN = '0; CALL_TOS_IN = '0; RET_VALUE_IN = '0;
        repeat (2) @(negedge clk);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_depth", 32'(DEPTH_OUT), 32'd0);
        reset = 1'b1;

        // 1: reset in the middle of a CALL
        @(negedge clk);
        CALL_PC_IN = 12'h321; CALL_TOS_IN = 12'h654; CALL_REQ = 1'b1;
        @(posedge clk);
        #1 chk("mid_busy_pre", 32'(BUSY), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(BUSY), 32'd0);
        chk("mid_done", 32'(DONE), 32'd0);
        chk("mid_sp", 32'(DEPTH_OUT), 32'd0);
        chk("mid_empty", 32'(EMPTY), 32'd1);
        chk("mid_outs", {RET_PC_OUT, STACK_TOS_RETURN, REG_DATA_RETURN}, 32'd0);
        chk("mid_flags", {FULL, OVF_ERR, UNF_ERR}, 32'd0);
        @(negedge clk);
        CALL_REQ = 1'b0;
        reset = 1'b1;

        // 2: single CALL / RET
        do_call(12'h123, 12'h045, lat);
        chk("call_lat", 32'(lat), 32'd1);
        chk("call_depth", 32'(DEPTH_OUT), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(DONE), 32'd0);
        do_ret(8'hA5, lat);
        chk("ret_lat", 32'(lat), 32'd2);
        chk("ret_pc", 32'(RET_PC_OUT), 32'h123);
        chk("ret_tos", 32'(STACK_TOS_RETURN), 32'h045);
        chk("ret_val", 32'(REG_DATA_RETURN), 32'hA5);
        chk("ret_empty", 32'(EMPTY), 32'd1);
        chk("ret_done_low", 32'(DONE), 32'd0);

        // 5: underflow; CLR_ERR held across the erroring edge must not win
        CLR_ERR = 1'b1;
        RET_VALUE_IN = 8'h5A;
        op(1'b0, 1'b1, lat);
        chk("unf_lat", 32'(lat), 32'd1);
        chk("unf_flag", 32'(UNF_ERR), 32'd1);
        chk("unf_pc_held", 32'(RET_PC_OUT), 32'h123);
        chk("unf_val_held", 32'(REG_DATA_RETURN), 32'hA5);
        @(negedge clk);
        CLR_ERR = 1'b0;
        chk("unf_clr", 32'(UNF_ERR), 32'd0);

        // 3/4: fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            do_call(12'(i), 12'(12'h100 + i), lat);
            if (i == 15) chk("fill_lat", 32'(lat), 32'd1);
        end
        @(negedge clk);
        chk("full", 32'(FULL), 32'd1);
        chk("full_depth", 32'(DEPTH_OUT), 32'd16);
`ifdef CFS_DEPTH_MON_EN
        chk("max16", 32'(MAX_DEPTH_OUT), 32'd16);
`else
        chk("max_tied", 32'(MAX_DEPTH_OUT), 32'd0);
`endif
        do_call(12'h7FF, 12'h7EE, lat);
        chk("ovf_lat", 32'(lat), 32'd1);
        chk("ovf_flag", 32'(OVF_ERR), 32'd1);
        chk("ovf_depth", 32'(DEPTH_OUT), 32'd16);
        @(negedge clk);
        CLR_ERR = 1'b1;
        @(negedge clk);
        CLR_ERR = 1'b0;
        chk("ovf_clr", 32'(OVF_ERR), 32'd0);
        for (int i = 15; i >= 0; i--) begin
            do_ret(8'(8'h10 + i), lat);
            chk($sformatf("lifo_pc%0d", i), 32'(RET_PC_OUT), 32'(i));
            chk($sformatf("lifo_tos%0d", i), 32'(STACK_TOS_RETURN), 32'(12'h100 + i));
            chk($sformatf("lifo_val%0d", i), 32'(REG_DATA_RETURN), 32'(8'h10 + i));
            if (i == 15) chk("notfull", 32'(FULL), 32'd0);
        end
        chk("drain_empty", 32'(EMPTY), 32'd1);

        // 6: simultaneous requests, CALL wins
        pulse_reset();
        do_call(12'h0AA, 12'h0BB, lat);
        CALL_PC_IN = 12'h0CC; CALL_TOS_IN = 12'h0DD; RET_VALUE_IN = 8'h77;
        op(1'b1, 1'b1, lat);
        chk("both_lat", 32'(lat), 32'd1);
        chk("both_depth", 32'(DEPTH_OUT), 32'd2);
        do_ret(8'h01, lat);
        chk("both_pc_top", 32'(RET_PC_OUT), 32'h0CC);
        chk("both_tos_top", 32'(STACK_TOS_RETURN), 32'h0DD);
        do_ret(8'h02, lat);
        chk("both_pc_bot", 32'(RET_PC_OUT), 32'h0AA);
        chk("both_empty", 32'(EMPTY), 32'd1);
`ifdef CFS_DEPTH_MON_EN
        chk("max2", 32'(MAX_DEPTH_OUT), 32'd2);
`else
        chk("max_tied2", 32'(MAX_DEPTH_OUT), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
